// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the decode stage:
// class codes, field positions, illegal-op constants, error codes and FSM states.
package isa_pkg;

  localparam logic [1:0] CLS_MEM = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;

  localparam int COND_LSB    = 28;
  localparam int DP_BIT      = 27;
  localparam int OP4_BIT     = 26;
  localparam int I_BIT       = 25;
  localparam int BR_KIND_LSB = 24;
  localparam int OP_LSB      = 21;
  localparam int S_BIT       = 20;
  localparam int RN_LSB      = 16;
  localparam int RD_LSB      = 12;
  localparam int IMM24_W     = 24;

  localparam logic [4:0] DP_ILLEGAL_OP   = 5'b11111;
  localparam logic [2:0] MEM_ILLEGAL_HI3 = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_RANGE   = 2'b10,
    ERR_WRAP    = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_ERR
  } enc_state_e;

  typedef struct packed {
    logic [1:0]  cls;
    logic [4:0]  aluop;
    logic        imm;
    logic        setflags;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
  } desc_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer for one micro-op descriptor, with legality and
// branch-range checks; the branch offset is relative to wr_addr+2.
module instr_pack import isa_pkg::*; #(
  parameter int ADDR_W = 16
) (
  input  desc_t             desc,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       word,
  output logic              illegal,
  output logic              out_of_range
);

  localparam int DW = ADDR_W + 1;

  logic [DW-1:0]      diff;
  logic [IMM24_W-1:0] imm24;
  logic               range_bad;

  assign diff = {1'b0, target} - ({1'b0, wr_addr} + DW'(2));

  // Wide address spaces must prove the offset fits in a signed 24-bit field.
  if (DW >= IMM24_W) begin : g_wide
    logic [DW-IMM24_W:0] hi;
    assign hi        = diff[DW-1:IMM24_W-1];
    assign imm24     = diff[IMM24_W-1:0];
    assign range_bad = !((&hi) || !(|hi));
  end else begin : g_narrow
    assign imm24     = {{(IMM24_W-DW){diff[DW-1]}}, diff};
    assign range_bad = 1'b0;
  end

  always_comb begin
    word         = '0;
    illegal      = 1'b0;
    out_of_range = 1'b0;
    word[COND_LSB +: 4] = desc.cond;
    if (desc.cls[1]) begin
      word[DP_BIT]          = 1'b1;
      word[OP4_BIT]         = desc.aluop[4];
      word[I_BIT]           = desc.imm;
      word[OP_LSB +: 4]     = desc.aluop[3:0];
      word[S_BIT]           = desc.setflags;
      word[RN_LSB +: 4]     = desc.rn;
      word[RD_LSB +: 4]     = desc.rd;
      word[11:0]            = desc.src2;
      illegal               = (desc.aluop == DP_ILLEGAL_OP);
    end else if (desc.cls == CLS_MEM) begin
      word[I_BIT]           = desc.imm;
      word[OP_LSB +: 4]     = desc.aluop[3:0];
      word[RN_LSB +: 4]     = desc.rn;
      word[RD_LSB +: 4]     = desc.rd;
      word[11:0]            = desc.src2;
      illegal               = desc.aluop[4] | (desc.aluop[3:1] == MEM_ILLEGAL_HI3);
    end else begin
      word[OP4_BIT]          = 1'b1;
      word[BR_KIND_LSB +: 2] = desc.aluop[1:0];
      word[IMM24_W-1:0]      = imm24;
      illegal                = |desc.aluop[4:2];
      out_of_range           = range_bad;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words into instruction memory from a base address.
// States: IDLE wait start | RUN accept descriptors | DRAIN flush last word | ERR halted, sticky error.
module instr_encoder import isa_pkg::*; #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_class,
  input  logic [4:0]        in_aluop,
  input  logic              in_imm,
  input  logic              in_setflags,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [ADDR_W-1:0] in_target,
  output logic              imem_valid,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wrap_q, wrap_d;
  logic              imem_valid_q, imem_valid_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_code_e         err_code_q, err_code_d;

  desc_t       desc;
  logic [31:0] word;
  logic        illegal;
  logic        out_of_range;
  logic        in_ready_c;

  assign desc = '{cls: in_class, aluop: in_aluop, imm: in_imm, setflags: in_setflags,
                  cond: in_cond, rn: in_rn, rd: in_rd, src2: in_src2};

  instr_pack #(.ADDR_W(ADDR_W)) u_pack (
    .desc         (desc),
    .target       (in_target),
    .wr_addr      (wr_addr_q),
    .word         (word),
    .illegal      (illegal),
    .out_of_range (out_of_range)
  );

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    wrap_d       = wrap_q;
    imem_valid_d = imem_valid_q & ~imem_ready;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    in_ready_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          wr_addr_d = base_addr;
          wrap_d    = 1'b0;
        end
      end
      ST_RUN: begin
        in_ready_c = ~imem_valid_q | imem_ready;
        if (in_valid && in_ready_c) begin
          // A faulty descriptor is never written; any unaccepted word is dropped too.
          if (illegal || out_of_range || wrap_q) begin
            state_d      = ST_ERR;
            error_d      = 1'b1;
            imem_valid_d = 1'b0;
            err_code_d   = illegal ? ERR_ILLEGAL : (out_of_range ? ERR_RANGE : ERR_WRAP);
          end else begin
            imem_valid_d = 1'b1;
            imem_addr_d  = wr_addr_q;
            imem_wdata_d = word;
            wr_addr_d    = wr_addr_q + ADDR_W'(1);
            wrap_d       = &wr_addr_q;
            if (in_last) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (imem_valid_q && imem_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ERR: begin
        imem_valid_d = 1'b0;
        if (start) begin
          state_d    = ST_RUN;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          wr_addr_d  = base_addr;
          wrap_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      wrap_q       <= 1'b0;
      imem_valid_q <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wrap_q       <= wrap_d;
      imem_valid_q <= imem_valid_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign imem_valid = imem_valid_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed and randomized descriptor streams scored
// against an arithmetic encoding model and an expected-write queue.
module tb_instr_encoder;

  localparam int AW   = 16;
  localparam int AW26 = 26;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_ERR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid, in_ready, in_last;
  logic [1:0]    in_class;
  logic [4:0]    in_aluop;
  logic          in_imm, in_setflags;
  logic [3:0]    in_cond, in_rn, in_rd;
  logic [11:0]   in_src2;
  logic [AW-1:0] in_target;
  logic          imem_valid, imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, error;
  logic [1:0]    err_code;

  logic            e_start;
  logic [AW26-1:0] e_base_addr;
  logic            e_in_valid, e_in_ready, e_in_last;
  logic [1:0]      e_in_class;
  logic [4:0]      e_in_aluop;
  logic            e_in_imm, e_in_setflags;
  logic [3:0]      e_in_cond, e_in_rn, e_in_rd;
  logic [11:0]     e_in_src2;
  logic [AW26-1:0] e_in_target;
  logic            e_imem_valid, e_imem_ready;
  logic [AW26-1:0] e_imem_addr;
  logic [31:0]     e_imem_wdata;
  logic            e_busy, e_done, e_error;
  logic [1:0]      e_err_code;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_class(in_class), .in_aluop(in_aluop), .in_imm(in_imm), .in_setflags(in_setflags),
    .in_cond(in_cond), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_target(in_target),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  instr_encoder #(.ADDR_W(AW26)) dut26 (
    .clk(clk), .reset(reset), .start(e_start), .base_addr(e_base_addr),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_last(e_in_last),
    .in_class(e_in_class), .in_aluop(e_in_aluop), .in_imm(e_in_imm), .in_setflags(e_in_setflags),
    .in_cond(e_in_cond), .in_rn(e_in_rn), .in_rd(e_in_rd), .in_src2(e_in_src2), .in_target(e_in_target),
    .imem_valid(e_imem_valid), .imem_ready(e_imem_ready), .imem_addr(e_imem_addr), .imem_wdata(e_imem_wdata),
    .busy(e_busy), .done(e_done), .error(e_error), .err_code(e_err_code)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          m_phase;
  longint      m_addr;
  logic [1:0]  m_code;
  bit          m_done;
  bit          m_accepted;
  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=stalled expected=progress", tag);
  endtask

  // Encoding rules as plain arithmetic; err: 0 ok, 1 illegal, 2 range, 3 wrap.
  // addr is an unbounded running address, so wrapping shows up as addr >= 2^aw.
  function automatic void model_encode(input int aw, input logic [1:0] cls, input logic [4:0] op,
                                       input logic i, input logic s, input logic [3:0] cond,
                                       input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                                       input longint tgt, input longint addr,
                                       output logic [31:0] word, output int err);
    longint      lim, m, d;
    logic [31:0] w;
    lim = longint'(1) << aw;
    err = 0;
    w = 32'(cond) << 28;
    if (cls[1]) begin
      if (op == 5'd31) err = 1;
      w = w | (32'd1 << 27) | (32'(op[4]) << 26) | (32'(i) << 25) | (32'(op[3:0]) << 21)
            | (32'(s) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(src2);
    end else if (cls == 2'b00) begin
      if (op[4] || op[3:0] >= 4'd14) err = 1;
      w = w | (32'(i) << 25) | (32'(op[3:0]) << 21) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(src2);
    end else begin
      if (op[4:2] != 3'b000) err = 1;
      m = lim * 2;
      d = tgt - ((addr % lim) + 2);
      d = ((d % m) + m) % m;
      if (d >= lim) d = d - m;
      if (err == 0 && (d < -(longint'(1) << 23) || d >= (longint'(1) << 23))) err = 2;
      w = w | (32'd1 << 26) | (32'(op[1:0]) << 24) | (32'(d) & 32'h00FF_FFFF);
    end
    if (err == 0 && addr >= lim) err = 3;
    word = w;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_addr  = 0;
    m_code  = 2'b00;
    m_done  = 1'b0;
    q_addr.delete();
    q_data.delete();
  endtask

  // Called at a falling edge with inputs already driven; checks, predicts, advances one cycle.
  task automatic tick();
    int          ph0;
    bit          exp_rdy;
    bit          nd;
    logic [31:0] w;
    int          e;
    #1;
    ph0     = m_phase;
    exp_rdy = (m_phase == P_RUN) && (q_data.size() == 0 || imem_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("imem_valid", 32'(imem_valid), 32'(q_data.size() != 0));
    if (q_data.size() != 0) begin
      chk("imem_addr", 32'(imem_addr), 32'(q_addr[0]));
      chk("imem_wdata", imem_wdata, q_data[0]);
    end
    chk("busy", 32'(busy), 32'(m_phase == P_RUN || m_phase == P_DRAIN));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_phase == P_ERR));
    chk("err_code", 32'(err_code), 32'(m_phase == P_ERR ? m_code : 2'b00));
    nd = 1'b0;
    m_accepted = 1'b0;
    if (q_data.size() != 0 && imem_ready) begin
      void'(q_data.pop_front());
      void'(q_addr.pop_front());
      if (m_phase == P_DRAIN) begin
        m_phase = P_IDLE;
        nd = 1'b1;
      end
    end
    if (ph0 == P_RUN && in_valid && exp_rdy) begin
      m_accepted = 1'b1;
      model_encode(AW, in_class, in_aluop, in_imm, in_setflags, in_cond, in_rn, in_rd, in_src2,
                   longint'(in_target), m_addr, w, e);
      if (e != 0) begin
        m_phase = P_ERR;
        m_code  = 2'(e);
        q_addr.delete();
        q_data.delete();
      end else begin
        q_addr.push_back(16'(m_addr));
        q_data.push_back(w);
        m_addr++;
        if (in_last) m_phase = P_DRAIN;
      end
    end
    if ((ph0 == P_IDLE || ph0 == P_ERR) && start) begin
      m_phase = P_RUN;
      m_addr  = longint'(base_addr);
    end
    m_done = nd;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [1:0] cls, input logic [4:0] op, input logic i, input logic s,
                      input logic [3:0] cond, input logic [3:0] rn, input logic [3:0] rd,
                      input logic [11:0] src2, input logic [15:0] tgt, input logic last, input bit rnd);
    int n = 0;
    in_valid = 1'b1; in_class = cls; in_aluop = op; in_imm = i; in_setflags = s;
    in_cond = cond; in_rn = rn; in_rd = rd; in_src2 = src2; in_target = tgt; in_last = last;
    do begin
      if (rnd) begin
        imem_ready = ($urandom_range(0, 3) != 0);
        start      = ($urandom_range(0, 15) == 0);
        base_addr  = 16'($urandom);
      end
      tick();
      n++;
    end while (!m_accepted && n < 100);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    if (!m_accepted) timeout("accept");
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (m_phase == P_DRAIN && n < 100) begin
      imem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      n++;
    end
    imem_ready = 1'b1;
    if (m_phase == P_DRAIN) timeout("drain");
    tick();
  endtask

  task automatic reset_check16(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_imem_valid"}, 32'(imem_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          e;
    reset = 1'b1; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_last = 1'b0; in_class = '0; in_aluop = '0; in_imm = 1'b0; in_setflags = 1'b0;
    in_cond = '0; in_rn = '0; in_rd = '0; in_src2 = '0; in_target = '0; imem_ready = 1'b1;
    e_start = 1'b0; e_base_addr = '0; e_in_valid = 1'b0; e_in_last = 1'b0; e_in_class = '0;
    e_in_aluop = '0; e_in_imm = 1'b0; e_in_setflags = 1'b0; e_in_cond = '0; e_in_rn = '0;
    e_in_rd = '0; e_in_src2 = '0; e_in_target = '0; e_imem_ready = 1'b1;
    model_reset();
    #1;
    reset_check16("rst");
    chk("rst_e_imem_valid", 32'(e_imem_valid), 32'd0);
    chk("rst_e_error", 32'(e_error), 32'd0);
    chk("rst_e_err_code", 32'(e_err_code), 32'd0);
    chk("rst_e_imem_addr", 32'(e_imem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single DP word at 0x0100, then done and busy fall.
    do_start(16'h0100);
    send(2'b10, 5'b00000, 1'b1, 1'b1, 4'hE, 4'd1, 4'd2, 12'h005, 16'h0, 1'b1, 1'b0);
    wait_idle(1'b0);

    // Backward branch.
    do_start(16'h0104);
    send(2'b01, 5'b00000, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 12'h000, 16'h0100, 1'b1, 1'b0);
    wait_idle(1'b0);

    // Memory op held under backpressure for three cycles.
    do_start(16'h0300);
    send(2'b00, 5'b00001, 1'b1, 1'b0, 4'hE, 4'd3, 4'd4, 12'h008, 16'h0, 1'b1, 1'b0);
    imem_ready = 1'b0;
    repeat (3) tick();
    wait_idle(1'b0);

    // Illegal DP op as the second descriptor; start then clears the error.
    do_start(16'h0200);
    send(2'b11, 5'b00100, 1'b0, 1'b1, 4'h0, 4'd5, 4'd6, 12'h123, 16'h0, 1'b0, 1'b0);
    send(2'b10, 5'b11111, 1'b0, 1'b0, 4'hE, 4'd1, 4'd1, 12'h001, 16'h0, 1'b0, 1'b0);
    tick();
    do_start(16'h0210);
    send(2'b10, 5'b00010, 1'b1, 1'b0, 4'h1, 4'd7, 4'd8, 12'hABC, 16'h0, 1'b1, 1'b0);
    wait_idle(1'b0);

    // Last address is writable once; the next descriptor reports wrap.
    do_start(16'hFFFF);
    send(2'b10, 5'b00011, 1'b0, 1'b0, 4'hE, 4'd2, 4'd3, 12'h044, 16'h0, 1'b0, 1'b0);
    send(2'b10, 5'b00011, 1'b0, 1'b0, 4'hE, 4'd2, 4'd3, 12'h045, 16'h0, 1'b1, 1'b0);
    tick();

    for (int r = 0; r < 40; r++) begin
      logic [15:0] b;
      logic [1:0]  c;
      logic [4:0]  o;
      int          n;
      b = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      do_start(b);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        if (m_phase != P_RUN) break;
        repeat ($urandom_range(0, 2)) begin
          imem_ready = ($urandom_range(0, 1) != 0);
          tick();
        end
        c = 2'($urandom);
        if ($urandom_range(0, 7) == 0) o = 5'($urandom);
        else if (c[1]) o = 5'($urandom_range(0, 30));
        else if (c == 2'b00) o = 5'($urandom_range(0, 13));
        else o = 5'($urandom_range(0, 3));
        send(c, o, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             12'($urandom), 16'($urandom), (k == n - 1), 1'b1);
      end
      wait_idle(1'b1);
    end

    // Reset in the middle of a stalled write.
    do_start(16'h0400);
    imem_ready = 1'b0;
    send(2'b10, 5'b00001, 1'b1, 1'b1, 4'h3, 4'd9, 4'd10, 12'h0F0, 16'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    reset_check16("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b1;
    tick();

    // 26-bit address space: an in-range branch writes, an out-of-range one faults.
    e_start = 1'b1; e_base_addr = '0;
    @(negedge clk);
    e_start = 1'b0;
    e_in_valid = 1'b1; e_in_class = 2'b01; e_in_aluop = 5'b00010; e_in_cond = 4'hE;
    e_in_target = 26'h0800001; e_in_last = 1'b1;
    model_encode(AW26, 2'b01, 5'b00010, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 12'h0, 64'h0800001, 0, w, e);
    #1;
    chk("e_in_ready_run", 32'(e_in_ready), 32'd1);
    @(negedge clk);
    e_in_valid = 1'b0; e_in_last = 1'b0;
    #1;
    chk("e_near_err", 32'(e_error), 32'(e != 0));
    chk("e_near_valid", 32'(e_imem_valid), 32'd1);
    chk("e_near_addr", 32'(e_imem_addr), 32'd0);
    chk("e_near_wdata", e_imem_wdata, w);
    @(negedge clk);
    #1;
    chk("e_near_done", 32'(e_done), 32'd1);
    @(negedge clk);
    e_start = 1'b1; e_base_addr = '0;
    @(negedge clk);
    e_start = 1'b0;
    e_in_valid = 1'b1; e_in_class = 2'b01; e_in_aluop = 5'b00000; e_in_cond = 4'hE;
    e_in_target = 26'h1000000; e_in_last = 1'b1;
    model_encode(AW26, 2'b01, 5'b00000, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 12'h0, 64'h1000000, 0, w, e);
    @(negedge clk);
    e_in_valid = 1'b0; e_in_last = 1'b0;
    #1;
    chk("e_far_error", 32'(e_error), 32'(e != 0));
    chk("e_far_err_code", 32'(e_err_code), 32'(e));
    chk("e_far_valid", 32'(e_imem_valid), 32'd0);
    chk("e_far_busy", 32'(e_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
